// File: rtl/pixel_hit_counter_if.sv
// pixel_hit_counter_if: arbiter, frame-control and readout-chain signals of one pixel hit counter
interface pixel_hit_counter_if;
  logic winerAll;
  logic countEnable;
  logic frameToggle;
  logic shiftEnable;
  logic shiftIn;
  logic shiftOut;
  logic activeBank;
  modport master(output winerAll, countEnable, frameToggle, shiftEnable, shiftIn, input shiftOut, activeBank);
  modport slave(input winerAll, countEnable, frameToggle, shiftEnable, shiftIn, output shiftOut, activeBank);
endinterface

// File: rtl/pixel_hit_counter.sv
// pixel_hit_counter: double-banked pixel hit counter with serial readout chain.
// Define PIXEL_HIT_COUNTER_SAT_FLAG_EN for saturating counters with a sticky flag appended to readout.
module pixel_hit_counter #(
  parameter int COUNTER_WIDTH = 12,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rstn,
  pixel_hit_counter_if.slave bus
);
`ifdef PIXEL_HIT_COUNTER_SAT_FLAG_EN
  localparam int RW = COUNTER_WIDTH + 1;
`else
  localparam int RW = COUNTER_WIDTH;
`endif
  typedef enum logic {ARMED, BUSY} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic win, hit, bank;
  logic [COUNTER_WIDTH-1:0] cnt0, cnt1, cnt_act, cnt_nxt;
  logic [RW-1:0] rd, load;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sync <= '0;
      state <= ARMED;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.winerAll};
      state <= state_nxt;
    end
  // only the ARMED->BUSY edge is a hit, so a long pulse counts once
  always_comb begin
    win = sync[SYNC_STAGES-1];
    state_nxt = win ? BUSY : ARMED;
    hit = state == ARMED && win && bus.countEnable;
    cnt_act = bank ? cnt1 : cnt0;
  end
`ifdef PIXEL_HIT_COUNTER_SAT_FLAG_EN
  logic flag0, flag1, flag_act, flag_nxt, at_max;
  always_comb begin
    at_max = &cnt_act;
    flag_act = bank ? flag1 : flag0;
    cnt_nxt = hit && !at_max ? cnt_act + COUNTER_WIDTH'(1) : cnt_act;
    flag_nxt = flag_act | (hit & at_max);
    load = {cnt_nxt, flag_nxt};
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      flag0 <= 1'b0;
      flag1 <= 1'b0;
    end else begin
      flag0 <= bank ? (bus.frameToggle ? 1'b0 : flag0) : flag_nxt;
      flag1 <= bank ? flag_nxt : (bus.frameToggle ? 1'b0 : flag1);
    end
`else
  always_comb begin
    cnt_nxt = hit ? cnt_act + COUNTER_WIDTH'(1) : cnt_act;
    load = cnt_nxt;
  end
`endif
  // the readout captures cnt_nxt so a hit coinciding with the toggle is kept
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt0 <= '0;
      cnt1 <= '0;
      bank <= 1'b0;
      rd <= '0;
    end else begin
      cnt0 <= bank ? (bus.frameToggle ? '0 : cnt0) : cnt_nxt;
      cnt1 <= bank ? cnt_nxt : (bus.frameToggle ? '0 : cnt1);
      bank <= bank ^ bus.frameToggle;
      rd <= bus.frameToggle ? load : bus.shiftEnable ? {rd[RW-2:0], bus.shiftIn} : rd;
    end
  assign bus.shiftOut = rd[RW-1];
  assign bus.activeBank = bank;
endmodule

// File: doc/pixel_hit_counter.md
PIXEL_HIT_COUNTER -- requirements
Module: pixel_hit_counter

Interface
REQ-001 Parameter COUNTER_WIDTH, default 12: width of each hit counter in bits.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of the winerAll synchronizer; minimum 2.
REQ-003 clk  input  1  single block clock; all state updates on its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 winerAll  input  1  arbitration-winner level from the pixel arbiter; asynchronous to clk.
REQ-006 countEnable  input  1  when high, qualified hits are counted; when low, hits are ignored.
REQ-007 frameToggle  input  1  single-cycle pulse; swaps the counting bank and loads the readout register.
REQ-008 shiftEnable  input  1  when high, the readout register shifts by one bit per cycle.
REQ-009 shiftIn  input  1  serial data from the upstream pixel in the readout chain.
REQ-010 shiftOut  output  1  serial data to the downstream pixel; equals the readout register MSB.
REQ-011 activeBank  output  1  index (0/1) of the counter currently accumulating hits.

Function
REQ-012 The block SHALL pass winerAll through a SYNC_STAGES flip-flop synchronizer before any use.
REQ-013 The hit FSM SHALL have two states, ARMED and BUSY.
- ARMED to BUSY when the synchronized winerAll is 1.
- BUSY to ARMED when the synchronized winerAll is 0.
REQ-014 The ARMED-to-BUSY transition SHALL be the only hit event: one increment per winerAll high pulse, regardless of pulse length.
REQ-015 A hit event SHALL be counted only if countEnable is 1 in the cycle of the transition.
- The FSM SHALL track winerAll regardless of countEnable.
REQ-016 Latency from a winerAll rising edge to the counter increment SHALL be SYNC_STAGES+1 clk cycles.
REQ-017 Two counters, bank0 and bank1, SHALL exist; only the counter selected by activeBank increments.
REQ-018 On a frameToggle cycle, all of the following SHALL happen:
- activeBank inverts.
- The readout register loads the outgoing counter's value, including any hit event in that same cycle.
- The incoming counter clears to 0.
REQ-019 When frameToggle and shiftEnable coincide, the load SHALL take priority and no shift occurs that cycle.
REQ-020 When shiftEnable is 1 and frameToggle is 0, the readout register SHALL shift toward the MSB each cycle, with shiftIn entering at the LSB.
REQ-021 frameToggle asserted on consecutive cycles SHALL swap banks on each cycle; each load captures the just-outgoing counter.
REQ-022 Counter behaviour at all-ones SHALL follow REQ-026/REQ-027.

Reset
REQ-023 While rstn is low, the block SHALL hold the following, with no clock required:
- both counters = 0
- readout register = 0
- synchronizer flops = 0
- FSM = ARMED
- activeBank = 0
- shiftOut = 0
REQ-024 Reset deassertion during a winerAll high level SHALL produce exactly one hit event once the level has propagated through the synchronizer.
REQ-025 Reset asserted mid-frame or mid-shift SHALL discard all counts and readout data with no partial output.

Configuration
REQ-026 With macro PIXEL_HIT_COUNTER_SAT_FLAG_EN defined, saturation SHALL apply:
- Each counter saturates at 2^COUNTER_WIDTH-1.
- A per-bank sticky saturation flag is set by any hit event at all-ones and cleared with its counter.
- The readout register is COUNTER_WIDTH+1 bits: the counter value, then the flag as LSB.
REQ-027 Without the macro, counters SHALL wrap modulo 2^COUNTER_WIDTH, no flag SHALL exist, and the readout register SHALL be COUNTER_WIDTH bits.

Verification
REQ-028 The bench SHALL cover these scenarios (COUNTER_WIDTH=12 unless stated):
- Reset, then 5 winerAll pulses (3 cycles high, 4 low) with countEnable=1, then frameToggle -> activeBank=1; 12 shifts output 000000000101 MSB first.
- One winerAll pulse held high 50 cycles -> exactly 1 count; with countEnable=0 during the pulse -> 0 counts.
- Hit event in the same cycle as frameToggle -> counted in the outgoing bank's loaded value; incoming bank reads 0.
- 4100 hits with the macro defined -> 13-bit readout 111111111111_1; without the macro -> 000000000100.
- frameToggle together with shiftEnable=1 while the register holds data -> load wins; the first shiftOut bit is the new value's MSB.
- rstn pulled low during a 6-bit-deep shift -> shiftOut=0 immediately; counters=0 and activeBank=0 after release.
